uart_program_loader: RTL

//   Serial program-load stage upstream of the cpu core. While the programming pin is high, it

---
 rtl/uart_program_loader_if.sv | 33 +++
 rtl/uart_program_loader.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_program_loader_if.sv
// ----------------------------------------------------------------------------
// uart_program_loader_if
//   Write port from the serial program loader into cpu program memory.
//
//   mem_we    one-cycle write strobe
//   mem_addr  write address (holds the last written address between strobes)
//   mem_data  instruction word {opcode, operand} (holds the last written word)
//
//   master : the loader, which drives the port
//   slave  : the program memory, which receives it
// ----------------------------------------------------------------------------
interface uart_program_loader_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 7
) ();

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;

    modport master (
        output mem_we,
        output mem_addr,
        output mem_data
    );

    modport slave (
        input mem_we,
        input mem_addr,
        input mem_data
    );

endinterface : uart_program_loader_if

// File: rtl/uart_program_loader.sv
// ----------------------------------------------------------------------------
// uart_program_loader
//   Serial program-load stage in front of the cpu core. While the programming
//   pin is high, 8N1 UART bytes arriving on rx_i are written one after another
//   into program memory, starting at address 0. The low
//   OPERATION_CODE_WIDTH+REGISTER_WIDTH bits of each byte form one instruction
//   word {opcode, operand}; any upper byte bits are discarded. Once
//   MEMORY_REGISTERS words have been written the loader sits in FULL with done_o
//   high and ignores further traffic until the programming pin is released.
//
// Ports
//   clk_i         single clock, all logic on the rising edge
//   reset_ni      synchronous reset, active low
//   p_programm_i  programming-mode request (asynchronous pin)
//   rx_i          UART serial data, idles high (asynchronous pin)
//   mem_if        program-memory write port (master side)
//   busy_o        a frame is being received or written
//   done_o        every program word has been written
//   frame_err_o   one-cycle pulse on a bad (low) stop bit
// ----------------------------------------------------------------------------
module uart_program_loader #(
    parameter int CLKS_PER_BIT         = 16,
    parameter int OPERATION_CODE_WIDTH = 3,
    parameter int REGISTER_WIDTH       = 4,
    parameter int MEMORY_ADDRESS_WIDTH = 4,
    parameter int MEMORY_REGISTERS     = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  p_programm_i,
    input  logic                  rx_i,
    uart_program_loader_if.master mem_if,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  frame_err_o
);

    localparam int DW    = OPERATION_CODE_WIDTH + REGISTER_WIDTH;
    localparam int AW    = MEMORY_ADDRESS_WIDTH;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    // Terminal counts of the bit-timing counter: the start bit is re-checked
    // half a bit after its falling edge, so every later sample falls mid-bit.
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [AW-1:0]    ADDR_LAST = AW'(MEMORY_REGISTERS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WRITE,
        S_FULL
    } state_e;

    // ------------------------------------------------------------------
    // Input synchronizers
    // ------------------------------------------------------------------
    logic rx_meta_q, rx_sync_q;
    logic prog_meta_q, prog_sync_q;

    // NOTE: reset values match each pin's idle level (rx idles high, prog
    // idles low), so the FSM never sees a phantom start bit or load request
    // while the synchronizers are still flushing after reset.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            prog_meta_q <= 1'b0;
            prog_sync_q <= 1'b0;
        end else begin
            rx_meta_q   <= rx_i;
            rx_sync_q   <= rx_meta_q;
            prog_meta_q <= p_programm_i;
            prog_sync_q <= prog_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Receiver / loader state
    // ------------------------------------------------------------------
    state_e            state_q,     state_d;
    logic [CNT_W-1:0]  clk_cnt_q,   clk_cnt_d;
    logic [2:0]        bit_cnt_q,   bit_cnt_d;
    logic [7:0]        shift_q,     shift_d;
    logic [AW-1:0]     addr_q,      addr_d;
    logic [AW-1:0]     mem_addr_q,  mem_addr_d;
    logic [DW-1:0]     mem_data_q,  mem_data_d;
    logic              frame_err_q, frame_err_d;
    // Set once rx has been seen high in IDLE; a new start bit is accepted
    // only after that, so a line held low after a bad stop bit cannot
    // retrigger reception.
    logic              armed_q,     armed_d;

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every flop samples the values from before the edge, independent of the
    // order in which the statements are written.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q     <= S_IDLE;
            clk_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            addr_q      <= '0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            frame_err_q <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            addr_q      <= addr_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            frame_err_q <= frame_err_d;
            armed_q     <= armed_d;
        end
    end

    // NOTE: every signal assigned below gets its hold/default value first, so
    // no path through the case statement can leave one unassigned and infer a
    // latch.
    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        addr_d      = addr_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        frame_err_d = 1'b0;
        armed_d     = armed_q;

        if (!prog_sync_q) begin
            // Leaving programming mode abandons any partial frame and rewinds
            // the load so the next rising edge of prog starts at address 0.
            state_d = S_IDLE;
            addr_d  = '0;
            armed_d = rx_sync_q;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rx_sync_q) begin
                        armed_d = 1'b1;
                    end else if (armed_q) begin
                        state_d   = S_START;
                        clk_cnt_d = '0;
                        bit_cnt_d = '0;
                        armed_d   = 1'b0;
                    end
                end

                S_START: begin
                    if (clk_cnt_q == HALF_LAST) begin
                        clk_cnt_d = '0;
                        // A line already back high mid start bit was a glitch.
                        state_d   = rx_sync_q ? S_IDLE : S_DATA;
                    end else begin
                        clk_cnt_d = clk_cnt_q + CNT_W'(1);
                    end
                end

                S_DATA: begin
                    if (clk_cnt_q == BIT_LAST) begin
                        clk_cnt_d = '0;
                        shift_d   = {rx_sync_q, shift_q[7:1]};  // LSB first
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = S_STOP;
                        end
                    end else begin
                        clk_cnt_d = clk_cnt_q + CNT_W'(1);
                    end
                end

                S_STOP: begin
                    if (clk_cnt_q == BIT_LAST) begin
                        clk_cnt_d = '0;
                        if (rx_sync_q) begin
                            // Capture the write now so address and data are
                            // valid in the same cycle as the strobe.
                            state_d    = S_WRITE;
                            mem_addr_d = addr_q;
                            mem_data_d = shift_q[DW-1:0];
                        end else begin
                            state_d     = S_IDLE;
                            frame_err_d = 1'b1;
                        end
                    end else begin
                        clk_cnt_d = clk_cnt_q + CNT_W'(1);
                    end
                end

                S_WRITE: begin
                    // The counter stops at the last word instead of wrapping.
                    if (addr_q == ADDR_LAST) begin
                        state_d = S_FULL;
                    end else begin
                        addr_d  = addr_q + AW'(1);
                        state_d = S_IDLE;
                    end
                end

                S_FULL: begin
                    state_d = S_FULL;
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all decoded from registered state, so they are glitch-free.
    // ------------------------------------------------------------------
    assign mem_if.mem_we   = (state_q == S_WRITE);
    assign mem_if.mem_addr = mem_addr_q;
    assign mem_if.mem_data = mem_data_q;

    assign busy_o      = (state_q == S_START) || (state_q == S_DATA) ||
                         (state_q == S_STOP)  || (state_q == S_WRITE);
    assign done_o      = (state_q == S_FULL);
    assign frame_err_o = frame_err_q;

endmodule : uart_program_loader
